// File: rtl/seg7_pkg.sv
// Shared seven-segment display types, encoding table and BCD helper.
// Used by the scan controller and by later display blocks.
package seg7_pkg;

   typedef enum logic [1:0] {
      SCAN_DIG0 = 2'd0,
      SCAN_DIG1 = 2'd1,
      SCAN_DIG2 = 2'd2,
      SCAN_DIG3 = 2'd3
   } scan_state_t;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_LOAD  = 2'd2
   } conv_state_t;

   localparam int SW_W       = 13;
   localparam int BCD_W      = 16;
   localparam int NUM_DIGITS = 4;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      if (d <= 4'd9) s = SEG_DIGIT[d];
      return s;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 (mod 16).
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: 13 shift cycles plus one LOAD cycle per conversion.
// bcd is valid while done is high.
module bcd_converter
   import seg7_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SW_W-1:0]   value,
   output logic              busy,
   output logic              done,
   output logic [BCD_W-1:0]  bcd
);

   conv_state_t      state;
   logic [SW_W-1:0]  sreg;
   logic [3:0]       cnt;
   logic [BCD_W-1:0] work;
   logic [BCD_W-1:0] adj;

   assign adj = bcd_adjust(work);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CONV_IDLE;
         sreg  <= '0;
         cnt   <= '0;
         work  <= '0;
      end else begin
         case (state)
            CONV_IDLE: begin
               if (start) begin
                  sreg  <= value;
                  work  <= '0;
                  cnt   <= '0;
                  state <= CONV_SHIFT;
               end
            end
            CONV_SHIFT: begin
               work <= {adj[BCD_W-2:0], sreg[SW_W-1]};
               sreg <= {sreg[SW_W-2:0], 1'b0};
               cnt  <= cnt + 4'd1;
               if (cnt == 4'(SW_W - 1)) state <= CONV_LOAD;
            end
            CONV_LOAD: state <= CONV_IDLE;
            default:   state <= CONV_IDLE;
         endcase
      end
   end

   assign busy = (state != CONV_IDLE);
   assign done = (state == CONV_LOAD);
   assign bcd  = work;

endmodule

// File: rtl/seg7_scan_controller.sv
// Four-digit common-anode display scanner fed by a 13-bit switch value.
// Converts to BCD in the background and multiplexes digits at REFRESH_DIV clk per slot.
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int         REFRESH_DIV = 100000,
   parameter bit         BLANK_LZ    = 1'b1,
   parameter logic [3:0] DP_MASK     = 4'b0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SW_W-1:0] SW,
   output logic [6:0]      segmentDisplay,
   output logic [3:0]      an,
   output logic            dp,
   output logic            conv_busy
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0]                tick_cnt;
   logic                         tick;
   logic [SW_W-1:0]              shadow;
   logic                         start;
   logic                         done;
   logic [BCD_W-1:0]             bcd;
   logic [NUM_DIGITS-1:0][3:0]   digit;
   logic [NUM_DIGITS-1:0]        blank;
   scan_state_t                  state;

   assign tick = (tick_cnt == CW'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)     tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   // Only a new value starts a conversion; changes while busy are picked up once idle.
   assign start = !conv_busy && (SW != shadow);

   always_ff @(posedge clk) begin
      if (reset)      shadow <= '0;
      else if (start) shadow <= SW;
   end

   bcd_converter u_conv (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .value (SW),
      .busy  (conv_busy),
      .done  (done),
      .bcd   (bcd)
   );

   // All four digits change together so a scan slot never shows a mixed value.
   always_ff @(posedge clk) begin
      if (reset)     digit <= '0;
      else if (done) digit <= bcd;
   end

   always_comb begin
      blank = '0;
      if (BLANK_LZ) begin
         blank[3] = (digit[3] == 4'd0);
         blank[2] = blank[3] && (digit[2] == 4'd0);
         blank[1] = blank[2] && (digit[1] == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= SCAN_DIG0;
         an             <= 4'b1111;
         segmentDisplay <= SEG_BLANK;
         dp             <= 1'b1;
      end else begin
         an             <= ~(4'b0001 << state);
         segmentDisplay <= blank[state] ? SEG_BLANK : seg_encode(digit[state]);
         dp             <= ~DP_MASK[state];
         if (tick) begin
            case (state)
               SCAN_DIG0: state <= SCAN_DIG1;
               SCAN_DIG1: state <= SCAN_DIG2;
               SCAN_DIG2: state <= SCAN_DIG3;
               default:   state <= SCAN_DIG0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed + random bench for seg7_scan_controller against a decimal-arithmetic display model.
module tb_seg7_scan_controller;

   localparam int         RDIV = 4;
   localparam logic [3:0] DPM  = 4'b0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] sw = '0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        conv_busy;

   int total = 0;
   int bad   = 0;

   // Model: value on the display, pending conversion, edges since reset
   int m_val = 0, m_conv = 0, m_shadow = 0, m_busy = 0, m_e = 0;
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int pow10 [4] = '{1, 10, 100, 1000};

   seg7_scan_controller #(
      .REFRESH_DIV (RDIV),
      .BLANK_LZ    (1'b1),
      .DP_MASK     (DPM)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .SW             (sw),
      .segmentDisplay (seg),
      .an             (an),
      .dp             (dp),
      .conv_busy      (conv_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic cyc();
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      int         s;
      @(posedge clk);
      if (reset) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         m_busy = 0; m_shadow = 0; m_val = 0; m_conv = 0; m_e = 0;
      end else begin
         s = (m_e / RDIV) % 4;
         e_an = 4'hF;
         e_an[s] = 1'b0;
         e_seg = (s > 0 && m_val < pow10[s]) ? 7'h7F : seg_tab[(m_val / pow10[s]) % 10];
         e_dp = !DPM[s];
         m_e++;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_val = m_conv;
         end else if (int'(sw) != m_shadow) begin
            m_shadow = int'(sw);
            m_conv   = int'(sw);
            m_busy   = 14;
         end
      end
      #1;
      chk("an",   7'(an),        7'(e_an));
      chk("seg",  seg,           e_seg);
      chk("dp",   7'(dp),        7'(e_dp));
      chk("busy", 7'(conv_busy), 7'(m_busy > 0));
   endtask

   initial begin
      reset = 1'b1; sw = '0;
      repeat (3) cyc();
      reset = 1'b0;
      repeat (8) cyc();

      sw = 13'd1234;  repeat (40) cyc();
      sw = 13'd7;     repeat (40) cyc();
      sw = 13'd0;     repeat (40) cyc();
      sw = 13'd8191;  repeat (40) cyc();

      sw = 13'd100;   repeat (5) cyc();
      sw = 13'd200;   repeat (40) cyc();

      sw = 13'd555;   repeat (6) cyc();
      reset = 1'b1;   cyc();
      reset = 1'b0;   repeat (40) cyc();

      for (int i = 0; i < 25; i++) begin
         sw    = 13'($urandom_range(0, 8191));
         reset = ($urandom_range(0, 9) == 0);
         cyc();
         reset = 1'b0;
         repeat ($urandom_range(1, 30)) cyc();
      end
      repeat (40) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
